// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared pipeline encodings for opcodes, op classes, ALU ops and the decode payload.
package decode_stage_pkg;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [3:0] ALU_ADD    = 4'b0000;
   typedef enum logic [2:0] {
      CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_SYSTEM, CLS_FENCE
   } op_class_e;
   typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] next_pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] store_data;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        rd_write;
      op_class_e   op_class;
      logic [3:0]  alu_op;
      logic [2:0]  funct3;
      logic        illegal;
   } payload_t;
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch, register-file and execute-side signals of the decode stage.
interface decode_stage_if;
   import decode_stage_pkg::*;
   logic        valid_in;
   logic [31:0] pc_in;
   logic [31:0] next_pc_in;
   logic [31:0] instr_in;
   logic        stall;
   logic        invalidate;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        valid_out;
   logic [31:0] pc_out;
   logic [31:0] next_pc_out;
   logic [31:0] rs1_val_out;
   logic [31:0] rs2_val_out;
   logic [31:0] store_data_out;
   logic [31:0] imm_out;
   logic [4:0]  rd_addr_out;
   logic        rd_write_out;
   op_class_e   op_class_out;
   logic [3:0]  alu_op_out;
   logic [2:0]  funct3_out;
   logic        illegal_out;
   modport master (
      output valid_in, pc_in, next_pc_in, instr_in, stall, invalidate, rs1_data, rs2_data,
      input  rs1_addr, rs2_addr, valid_out, pc_out, next_pc_out, rs1_val_out, rs2_val_out,
             store_data_out, imm_out, rd_addr_out, rd_write_out, op_class_out, alu_op_out,
             funct3_out, illegal_out
   );
   modport slave (
      input  valid_in, pc_in, next_pc_in, instr_in, stall, invalidate, rs1_data, rs2_data,
      output rs1_addr, rs2_addr, valid_out, pc_out, next_pc_out, rs1_val_out, rs2_val_out,
             store_data_out, imm_out, rd_addr_out, rd_write_out, op_class_out, alu_op_out,
             funct3_out, illegal_out
   );
endinterface

// File: rtl/decode_stage_imm_decode.sv
// imm_decode: combinational RV32I immediate extraction, sign-extended from instruction bit 31.
module imm_decode
   import decode_stage_pkg::*;
(
   input  logic [31:7] i_instr,
   input  imm_fmt_e    i_fmt,
   output logic [31:0] o_imm
);
   always_comb
      o_imm = (i_fmt == IMM_I) ? {{20{i_instr[31]}}, i_instr[31:20]} :
              (i_fmt == IMM_S) ? {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]} :
              (i_fmt == IMM_B) ? {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0} :
              (i_fmt == IMM_U) ? {i_instr[31:12], 12'h000} :
              (i_fmt == IMM_J) ? {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0} :
              32'h0;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: one-cycle RV32I decode with register-file operand selection and stall/flush control.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter bit ZERO_X0 = 1'b1
)(
   input logic       clk,
   input logic       rst_n,
   decode_stage_if.slave bus
);
   logic [6:0]  w_opc;
   logic [6:0]  w_f7;
   logic [2:0]  w_f3;
   logic [4:0]  w_rd;
   logic [31:0] w_rs1;
   logic [31:0] w_rs2;
   logic [31:0] w_imm;
   imm_fmt_e    w_fmt;
   op_class_e   w_cls;
   logic        w_illegal;
   payload_t    w_dec;
   payload_t    r_q;
   logic        r_valid;
   assign bus.rs1_addr = bus.instr_in[19:15];
   assign bus.rs2_addr = bus.instr_in[24:20];
   assign w_opc = bus.instr_in[6:0];
   assign w_f3  = bus.instr_in[14:12];
   assign w_f7  = bus.instr_in[31:25];
   assign w_rd  = bus.instr_in[11:7];
   assign w_rs1 = (ZERO_X0 && bus.rs1_addr == 5'd0) ? 32'h0 : bus.rs1_data;
   assign w_rs2 = (ZERO_X0 && bus.rs2_addr == 5'd0) ? 32'h0 : bus.rs2_data;
   // Opcode match covers instr[1:0], so non-32-bit encodings fall into the illegal default.
   always_comb begin
      w_fmt = IMM_I;
      w_cls = CLS_ALU;
      w_illegal = 1'b0;
      case (w_opc)
         OPC_OP: begin
            w_fmt = IMM_R;
            w_illegal = !(w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5)));
         end
         OPC_OP_IMM: w_illegal = (w_f3 == 3'd1 && w_f7 != 7'h00) ||
                                 (w_f3 == 3'd5 && w_f7 != 7'h00 && w_f7 != 7'h20);
         OPC_LUI, OPC_AUIPC: w_fmt = IMM_U;
         OPC_LOAD: begin
            w_cls = CLS_LOAD;
            w_illegal = w_f3 == 3'd3 || w_f3[2:1] == 2'b11;
         end
         OPC_STORE: begin
            w_cls = CLS_STORE;
            w_fmt = IMM_S;
            w_illegal = w_f3 > 3'd2;
         end
         OPC_BRANCH: begin
            w_cls = CLS_BRANCH;
            w_fmt = IMM_B;
            w_illegal = w_f3[2:1] == 2'b01;
         end
         OPC_JAL: begin
            w_cls = CLS_JAL;
            w_fmt = IMM_J;
         end
         OPC_JALR: begin
            w_cls = CLS_JALR;
            w_illegal = w_f3 != 3'd0;
         end
         OPC_SYSTEM: begin
            w_cls = CLS_SYSTEM;
            w_illegal = w_f3 == 3'd4;
         end
         OPC_FENCE: w_cls = CLS_FENCE;
         default: w_illegal = 1'b1;
      endcase
   end
   imm_decode u_imm (
      .i_instr (bus.instr_in[31:7]),
      .i_fmt   (w_fmt),
      .o_imm   (w_imm)
   );
   always_comb begin
      w_dec.pc = bus.pc_in;
      w_dec.next_pc = bus.next_pc_in;
      w_dec.store_data = bus.rs2_data;
      w_dec.imm = w_imm;
      w_dec.rd = w_rd;
      w_dec.funct3 = w_f3;
      w_dec.illegal = w_illegal;
      w_dec.op_class = w_illegal ? CLS_SYSTEM : w_cls;
      w_dec.alu_op = (w_opc == OPC_LUI || w_opc == OPC_AUIPC) ? ALU_ADD :
                     (w_opc == OPC_OP_IMM && w_f3 != 3'd5) ? {1'b0, w_f3} : {w_f7[5], w_f3};
      w_dec.rs1_val = (w_opc == OPC_LUI) ? 32'h0 : (w_opc == OPC_AUIPC) ? bus.pc_in : w_rs1;
      w_dec.rs2_val = (w_opc inside {OPC_OP_IMM, OPC_LUI, OPC_AUIPC}) ? w_imm : w_rs2;
      w_dec.rd_write = !w_illegal && w_rd != 5'd0 &&
                       (w_cls inside {CLS_ALU, CLS_LOAD, CLS_JAL, CLS_JALR} ||
                        (w_cls == CLS_SYSTEM && w_f3 != 3'd0));
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_q <= '0;
      end else if (bus.invalidate) begin
         r_valid <= 1'b0;
      end else if (!bus.stall) begin
         r_valid <= bus.valid_in;
         r_q <= w_dec;
      end
   assign bus.valid_out      = r_valid;
   assign bus.pc_out         = r_q.pc;
   assign bus.next_pc_out    = r_q.next_pc;
   assign bus.rs1_val_out    = r_q.rs1_val;
   assign bus.rs2_val_out    = r_q.rs2_val;
   assign bus.store_data_out = r_q.store_data;
   assign bus.imm_out        = r_q.imm;
   assign bus.rd_addr_out    = r_q.rd;
   assign bus.rd_write_out   = r_q.rd_write;
   assign bus.op_class_out   = r_q.op_class;
   assign bus.alu_op_out     = r_q.alu_op;
   assign bus.funct3_out     = r_q.funct3;
   assign bus.illegal_out    = r_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed decode vectors with hand-computed expectations; register xN reads 0x1000_0000+N.
module tb_decode_stage;
   import decode_stage_pkg::*;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   decode_stage_if bus ();
   decode_stage #(.ZERO_X0(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   assign bus.rs1_data = 32'h1000_0000 | 32'(bus.rs1_addr);
   assign bus.rs2_data = 32'h1000_0000 | 32'(bus.rs2_addr);
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic v);
      bus.instr_in = instr;
      bus.pc_in = pc;
      bus.next_pc_in = pc + 32'd4;
      bus.valid_in = v;
      step();
   endtask
   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      bus.valid_in = 1'b1;
      bus.pc_in = 32'h0;
      bus.next_pc_in = 32'h0;
      bus.instr_in = 32'hFFB10093;
      bus.stall = 1'b0;
      bus.invalidate = 1'b0;
      step();
      step();
      chk("rst_valid", 32'(bus.valid_out), 32'd0);
      chk("rst_pc", bus.pc_out, 32'h0);
      chk("rst_imm", bus.imm_out, 32'h0);
      chk("rst_rdw", 32'(bus.rd_write_out), 32'd0);
      rst_n = 1'b1;
      drive(32'hFFB10093, 32'h100, 1'b1);
      chk("addi_valid", 32'(bus.valid_out), 32'd1);
      chk("addi_pc", bus.pc_out, 32'h100);
      chk("addi_npc", bus.next_pc_out, 32'h104);
      chk("addi_rd", 32'(bus.rd_addr_out), 32'd1);
      chk("addi_imm", bus.imm_out, 32'hFFFFFFFB);
      chk("addi_rs2v", bus.rs2_val_out, 32'hFFFFFFFB);
      chk("addi_rs1v", bus.rs1_val_out, 32'h10000002);
      chk("addi_cls", 32'(bus.op_class_out), 32'd0);
      chk("addi_rdw", 32'(bus.rd_write_out), 32'd1);
      chk("addi_alu", 32'(bus.alu_op_out), 32'h0);
      drive(32'hFE208CE3, 32'h200, 1'b1);
      chk("beq_imm", bus.imm_out, 32'hFFFFFFF8);
      chk("beq_cls", 32'(bus.op_class_out), 32'd3);
      chk("beq_f3", 32'(bus.funct3_out), 32'd0);
      chk("beq_rdw", 32'(bus.rd_write_out), 32'd0);
      chk("beq_rs1v", bus.rs1_val_out, 32'h10000001);
      chk("beq_rs2v", bus.rs2_val_out, 32'h10000002);
      drive(32'h123452B7, 32'h300, 1'b1);
      chk("lui_rs1v", bus.rs1_val_out, 32'h0);
      chk("lui_rs2v", bus.rs2_val_out, 32'h12345000);
      chk("lui_rd", 32'(bus.rd_addr_out), 32'd5);
      chk("lui_rdw", 32'(bus.rd_write_out), 32'd1);
      drive(32'h00000000, 32'h304, 1'b1);
      chk("zero_ill", 32'(bus.illegal_out), 32'd1);
      chk("zero_rdw", 32'(bus.rd_write_out), 32'd0);
      chk("zero_valid", 32'(bus.valid_out), 32'd1);
      chk("zero_cls", 32'(bus.op_class_out), 32'd6);
      drive(32'h00001197, 32'h400, 1'b1);
      chk("auipc_rs1v", bus.rs1_val_out, 32'h400);
      chk("auipc_rs2v", bus.rs2_val_out, 32'h1000);
      chk("auipc_cls", 32'(bus.op_class_out), 32'd0);
      drive(32'h40208233, 32'h404, 1'b1);
      chk("sub_alu", 32'(bus.alu_op_out), 32'h8);
      chk("sub_rs2v", bus.rs2_val_out, 32'h10000002);
      chk("sub_imm", bus.imm_out, 32'h0);
      chk("sub_ill", 32'(bus.illegal_out), 32'd0);
      drive(32'h40209233, 32'h408, 1'b1);
      chk("badop_ill", 32'(bus.illegal_out), 32'd1);
      chk("badop_cls", 32'(bus.op_class_out), 32'd6);
      drive(32'h0020A423, 32'h40C, 1'b1);
      chk("sw_cls", 32'(bus.op_class_out), 32'd2);
      chk("sw_imm", bus.imm_out, 32'h8);
      chk("sw_data", bus.store_data_out, 32'h10000002);
      chk("sw_rdw", 32'(bus.rd_write_out), 32'd0);
      drive(32'h4033D313, 32'h410, 1'b1);
      chk("srai_alu", 32'(bus.alu_op_out), 32'hD);
      chk("srai_rs2v", bus.rs2_val_out, 32'h403);
      chk("srai_rs1v", bus.rs1_val_out, 32'h10000007);
      drive(32'h000000B3, 32'h414, 1'b1);
      chk("x0_rs1v", bus.rs1_val_out, 32'h0);
      chk("x0_rs2v", bus.rs2_val_out, 32'h0);
      drive(32'h300092F3, 32'h418, 1'b1);
      chk("csr_cls", 32'(bus.op_class_out), 32'd6);
      chk("csr_rdw", 32'(bus.rd_write_out), 32'd1);
      chk("csr_ill", 32'(bus.illegal_out), 32'd0);
      drive(32'h3000C2F3, 32'h41C, 1'b1);
      chk("sys4_ill", 32'(bus.illegal_out), 32'd1);
      drive(32'hFFB10093, 32'h420, 1'b0);
      chk("vin0_valid", 32'(bus.valid_out), 32'd0);
      drive(32'hFFB10093, 32'h500, 1'b1);
      bus.stall = 1'b1;
      drive(32'h123452B7, 32'h600, 1'b1);
      chk("stall1_pc", bus.pc_out, 32'h500);
      chk("stall1_rd", 32'(bus.rd_addr_out), 32'd1);
      step();
      chk("stall2_pc", bus.pc_out, 32'h500);
      chk("stall2_imm", bus.imm_out, 32'hFFFFFFFB);
      bus.stall = 1'b0;
      step();
      chk("unstall_pc", bus.pc_out, 32'h600);
      chk("unstall_rd", 32'(bus.rd_addr_out), 32'd5);
      bus.stall = 1'b1;
      bus.invalidate = 1'b1;
      step();
      chk("flush_valid", 32'(bus.valid_out), 32'd0);
      bus.stall = 1'b0;
      bus.invalidate = 1'b0;
      drive(32'hFFB10093, 32'h700, 1'b1);
      chk("recap_valid", 32'(bus.valid_out), 32'd1);
      bus.invalidate = 1'b1;
      step();
      chk("inval_valid", 32'(bus.valid_out), 32'd0);
      bus.invalidate = 1'b0;
      drive(32'h0020A423, 32'h800, 1'b1);
      rst_n = 1'b0;
      bus.stall = 1'b1;
      step();
      chk("mrst_valid", 32'(bus.valid_out), 32'd0);
      chk("mrst_pc", bus.pc_out, 32'h0);
      chk("mrst_npc", bus.next_pc_out, 32'h0);
      chk("mrst_rs1v", bus.rs1_val_out, 32'h0);
      chk("mrst_rs2v", bus.rs2_val_out, 32'h0);
      chk("mrst_sd", bus.store_data_out, 32'h0);
      chk("mrst_imm", bus.imm_out, 32'h0);
      chk("mrst_cls", 32'(bus.op_class_out), 32'd0);
      chk("mrst_f3", 32'(bus.funct3_out), 32'd0);
      rst_n = 1'b1;
      bus.stall = 1'b0;
      drive(32'h40208233, 32'h900, 1'b1);
      chk("post_rst_alu", 32'(bus.alu_op_out), 32'h8);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one parameter, ZERO_X0, default 1: when 1, rs1_val_out/rs2_val_out are forced to 0 for source address 0.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 valid_in  input  1  fetch output holds a valid instruction.
REQ-005 pc_in  input  32  instruction address.
REQ-006 next_pc_in  input  32  pc_in + 4.
REQ-007 instr_in  input  32  raw RV32I instruction word.
REQ-008 stall  input  1  hold all registered outputs.
REQ-009 invalidate  input  1  flush, from branch or trap.
REQ-010 rs1_addr  output  5  instr_in[19:15], combinational, to register file.
REQ-011 rs2_addr  output  5  instr_in[24:20], combinational, to register file.
REQ-012 rs1_data  input  32  register file read data, same cycle as rs1_addr.
REQ-013 rs2_data  input  32  register file read data, same cycle as rs2_addr.
REQ-014 valid_out  output  1  execute-stage payload valid.
REQ-015 pc_out  output  32  registered pc_in.
REQ-016 next_pc_out  output  32  registered next_pc_in.
REQ-017 rs1_val_out  output  32  ALU operand A.
REQ-018 rs2_val_out  output  32  ALU operand B.
REQ-019 store_data_out  output  32  rs2 value for STORE.
REQ-020 imm_out  output  32  sign-extended immediate.
REQ-021 rd_addr_out  output  5  destination register.
REQ-022 rd_write_out  output  1  destination write enable.
REQ-023 op_class_out  output  3  0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JAL, 5 JALR, 6 SYSTEM, 7 FENCE.
REQ-024 alu_op_out  output  4  {funct7[5], funct3}.
REQ-025 funct3_out  output  3  mem size/sign, branch condition, or CSR op.
REQ-026 illegal_out  output  1  illegal instruction flag.

Function
REQ-027 Latency SHALL be one cycle, with per-edge priority: reset > invalidate (valid_out<=0) > stall (hold every output) > capture (valid_out<=valid_in, payload<=decode of instr_in).
REQ-028 When valid_in=0 and a capture occurs, valid_out SHALL be 0; payload SHALL be don't-care.
REQ-029 Immediates SHALL follow RV32I I/S/B/U/J formats, sign-extended from bit 31; imm_out SHALL be 0 for R-type.
REQ-030 OP: rs1_val_out=rs1_data, rs2_val_out=rs2_data, alu_op={instr[30],funct3}.
REQ-031 OP-IMM: rs2_val_out=imm_out; alu_op[3]=instr[30] only when funct3=101, else 0.
REQ-032 LUI: class ALU, alu_op=0, rs1_val_out=0, rs2_val_out=imm_out.
REQ-033 AUIPC: class ALU, alu_op=0, rs1_val_out=pc_in, rs2_val_out=imm_out.
REQ-034 For all classes other than ALU, rs1_val_out=rs1_data and rs2_val_out=rs2_data.
REQ-035 store_data_out SHALL equal rs2_data for every class.
REQ-036 rd_write_out SHALL be 1 for ALU, LOAD, JAL, JALR and SYSTEM CSR ops (funct3!=0), and SHALL be 0 when rd=0 or illegal_out=1.
REQ-037 illegal_out SHALL be 1 for: instr[1:0]!=11; unknown opcode; LOAD funct3 in {3,6,7}; STORE funct3>2; BRANCH funct3 in {2,3}; JALR funct3!=0; OP funct7 not in {0x00,0x20}, or 0x20 with funct3 not in {0,5}; OP-IMM shift with invalid funct7; SYSTEM funct3=4.
REQ-038 An illegal instruction SHALL still produce valid_out=1, with op_class_out=6.

Reset
REQ-039 While rst_n=0 at a rising edge, every registered output SHALL become 0, regardless of stall or invalidate.

Structure
REQ-040 Opcode, op_class and alu_op encodings SHALL live in the shared pipeline package; immediate extraction SHALL be sub-module imm_decode (combinational).

Verification
REQ-041 Directed: instr_in=0xFFB10093 (addi x1,x2,-5), pc_in=0x100, valid_in=1 -> next cycle: valid_out=1, pc_out=0x100, rd_addr_out=1, imm_out=rs2_val_out=0xFFFFFFFB, op_class_out=0, rd_write_out=1.
REQ-042 Directed: instr_in=0xFE208CE3 (beq x1,x2,-8) -> imm_out=0xFFFFFFF8, op_class_out=3, funct3_out=0, rd_write_out=0.
REQ-043 Directed: instr_in=0x123452B7 (lui x5,0x12345) -> rs1_val_out=0, rs2_val_out=0x12345000, rd_addr_out=5; then instr_in=0x00000000 -> illegal_out=1, rd_write_out=0, valid_out=1.
REQ-044 Directed: capture A, then stall=1 for 2 cycles with B presented -> outputs stay A; stall=0 -> B one cycle later.
REQ-045 Directed: stall=1 and invalidate=1 together -> valid_out=0 next cycle; rst_n=0 for one cycle mid-stream with valid_in=1 -> all outputs 0.
